// File: rtl/vconv_gen.sv
`default_nettype none
// ============================================================================
// vconv_gen : 4-stage RGB -> RGB/YPbPr(601/709) converter, vsync-gated mode.
// Revision  : 1.0
// ============================================================================
module vconv_gen #(
    parameter int COLOR_W = 10,
    parameter int COEFF_W = 20
) (
    input  logic                       VCLK,
    input  logic                       RST,
    input  logic [1:0]                 mode_i,
    input  logic                       vdata_i_valid,
    input  logic [4+3*COLOR_W-1:0]     vdata_i,
    output logic                       vdata_o_valid,
    output logic [4+3*COLOR_W-1:0]     vdata_o,
    output logic [1:0]                 mode_o
);
    localparam int  WW    = 4 + 3*COLOR_W;
    localparam int  PW    = COLOR_W + COEFF_W;
    localparam int  SW    = PW + 3;
    localparam real SCALE = real'(64'd1 << COEFF_W);

    localparam logic signed [SW-1:0] HALF = SW'(1) <<< (COEFF_W - 1);
    localparam logic signed [SW-1:0] OFFS = SW'(1) <<< (COLOR_W - 1 + COEFF_W);
    localparam logic signed [SW-1:0] MAXV = SW'((1 << COLOR_W) - 1);

    typedef logic [8:0][COEFF_W-1:0] coef_t;

    function automatic logic [COEFF_W-1:0] quant(input real k);
        return COEFF_W'($rtoi(k * SCALE + 0.5));
    endfunction

    // Magnitudes only; order Y(r,g,b), Pb(r,g,b), Pr(r,g,b). Signs live in s3.
    function automatic coef_t coef_set(input real kr, input real kb);
        real   kg;
        coef_t c;
        kg   = 1.0 - kr - kb;
        c[0] = quant(kr);
        c[1] = quant(kg);
        c[2] = quant(kb);
        c[3] = quant(0.5 * kr / (1.0 - kb));
        c[4] = quant(0.5 * kg / (1.0 - kb));
        c[5] = quant(0.5);
        c[6] = quant(0.5);
        c[7] = quant(0.5 * kg / (1.0 - kr));
        c[8] = quant(0.5 * kb / (1.0 - kr));
        return c;
    endfunction

    localparam coef_t C601 = coef_set(0.299, 0.114);
    localparam coef_t C709 = coef_set(0.2126, 0.0722);

    function automatic logic signed [SW-1:0] ext(input logic [PW-1:0] p);
        return $signed({3'b000, p});
    endfunction

    function automatic logic [COLOR_W-1:0] sat(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] t;
        t = v >>> COEFF_W;
        if (t[SW-1])   return '0;
        if (t > MAXV)  return '1;
        return t[COLOR_W-1:0];
    endfunction

    // Mode latch and vsync falling-edge detect (valid words only)
    logic [1:0] pending, applied, mode_now;
    logic       prev_nvs, fall;

    always_comb begin
        fall     = vdata_i_valid && !vdata_i[WW-1] && prev_nvs;
        mode_now = fall ? pending : applied;
    end

    always_ff @(posedge VCLK) begin
        if (RST) begin
            pending  <= 2'b00;
            applied  <= 2'b00;
            prev_nvs <= 1'b1;
        end else begin
            pending <= (mode_i == 2'b11) ? 2'b00 : mode_i;
            applied <= mode_now;
            if (vdata_i_valid)
                prev_nvs <= vdata_i[WW-1];
        end
    end

    // Pipeline registers; sync, RGB and mode travel with each word
    logic                       s1_valid, s2_valid, s3_valid;
    logic [3:0]                 s1_sync, s2_sync, s3_sync;
    logic [2:0][COLOR_W-1:0]    s1_rgb, s2_rgb, s3_rgb;
    logic [1:0]                 s1_mode, s2_mode, s3_mode;
    logic [8:0][PW-1:0]         s2_prod;
    logic signed [SW-1:0]       s3_y, s3_pb, s3_pr;
    coef_t                      coef;

    always_comb begin
        coef = (s1_mode == 2'b10) ? C709 : C601;
    end

    always_ff @(posedge VCLK) begin
        if (RST) begin
            s1_valid <= 1'b0;  s1_sync <= '0;  s1_rgb <= '0;  s1_mode <= 2'b00;
            s2_valid <= 1'b0;  s2_sync <= '0;  s2_rgb <= '0;  s2_mode <= 2'b00;
            s3_valid <= 1'b0;  s3_sync <= '0;  s3_rgb <= '0;  s3_mode <= 2'b00;
            s2_prod  <= '0;
            s3_y     <= '0;
            s3_pb    <= '0;
            s3_pr    <= '0;
        end else begin
            s1_valid <= vdata_i_valid;
            s1_sync  <= vdata_i[WW-1 -: 4];
            s1_rgb   <= vdata_i[3*COLOR_W-1:0];
            s1_mode  <= mode_now;

            // s1_rgb[2] = R, [1] = G, [0] = B
            for (int i = 0; i < 9; i++)
                s2_prod[i] <= PW'(s1_rgb[2 - (i % 3)]) * PW'(coef[i]);
            s2_valid <= s1_valid;
            s2_sync  <= s1_sync;
            s2_rgb   <= s1_rgb;
            s2_mode  <= s1_mode;

            s3_y     <= ext(s2_prod[0]) + ext(s2_prod[1]) + ext(s2_prod[2]);
            s3_pb    <= ext(s2_prod[5]) - ext(s2_prod[3]) - ext(s2_prod[4]);
            s3_pr    <= ext(s2_prod[6]) - ext(s2_prod[7]) - ext(s2_prod[8]);
            s3_valid <= s2_valid;
            s3_sync  <= s2_sync;
            s3_rgb   <= s2_rgb;
            s3_mode  <= s2_mode;
        end
    end

    logic [COLOR_W-1:0] y_c, pb_c, pr_c;
    logic [WW-1:0]      out_word;

    always_comb begin
        y_c  = sat(s3_y + HALF);
        pb_c = sat(s3_pb + OFFS + HALF);
        pr_c = sat(s3_pr + OFFS + HALF);
        if (s3_mode == 2'b01 || s3_mode == 2'b10)
            out_word = {s3_sync, pr_c, y_c, pb_c};
        else
            out_word = {s3_sync, s3_rgb};
    end

    // Output stage holds data and reported mode across gaps
    always_ff @(posedge VCLK) begin
        if (RST) begin
            vdata_o_valid <= 1'b0;
            vdata_o       <= '0;
            mode_o        <= 2'b00;
        end else begin
            vdata_o_valid <= s3_valid;
            if (s3_valid) begin
                vdata_o <= out_word;
                mode_o  <= s3_mode;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_vconv_gen.sv
`default_nettype none
// ============================================================================
// tb_vconv_gen : scoreboard bench for vconv_gen (COLOR_W=10, COEFF_W=20).
// Revision     : 1.0
// ============================================================================
module tb_vconv_gen;
    logic        VCLK = 1'b0;
    logic        RST  = 1'b1;
    logic [1:0]  mode_i = 2'b00;
    logic        vdata_i_valid = 1'b0;
    logic [33:0] vdata_i = '0;
    logic        vdata_o_valid;
    logic [33:0] vdata_o;
    logic [1:0]  mode_o;

    vconv_gen #(.COLOR_W(10), .COEFF_W(20)) dut (
        .VCLK          (VCLK),
        .RST           (RST),
        .mode_i        (mode_i),
        .vdata_i_valid (vdata_i_valid),
        .vdata_i       (vdata_i),
        .vdata_o_valid (vdata_o_valid),
        .vdata_o       (vdata_o),
        .mode_o        (mode_o)
    );

    always #5 VCLK = ~VCLK;

    typedef struct {
        logic [33:0] word;
        logic [1:0]  mode;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [33:0] last_out = '0;
    logic [1:0]  last_mode = 2'b00;
    logic [1:0]  cur_m = 2'b00;
    logic [1:0]  pend_m = 2'b00;
    logic [1:0]  app_m = 2'b00;
    bit          prev_m = 1'b1;

    always @(posedge VCLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic longint q(input real k);
        return longint'($rtoi(k * 1048576.0 + 0.5));
    endfunction

    function automatic logic [9:0] fin(input longint x, input longint off);
        longint t;
        t = (x + off * 1048576 + 524288) >>> 20;
        if (t < 0)    return 10'd0;
        if (t > 1023) return 10'd1023;
        return t[9:0];
    endfunction

    function automatic logic [33:0] model(input logic [1:0] m, input logic [3:0] s,
                                          input logic [9:0] r, g, b);
        real    kr, kb, kg;
        longint ri, gi, bi, y, pb, pr;
        if (m != 2'b01 && m != 2'b10) return {s, r, g, b};
        kr = (m == 2'b01) ? 0.299 : 0.2126;
        kb = (m == 2'b01) ? 0.114 : 0.0722;
        kg = 1.0 - kr - kb;
        ri = longint'(r);  gi = longint'(g);  bi = longint'(b);
        y  = q(kr) * ri + q(kg) * gi + q(kb) * bi;
        pb = q(0.5) * bi - q(0.5 * kr / (1.0 - kb)) * ri - q(0.5 * kg / (1.0 - kb)) * gi;
        pr = q(0.5) * ri - q(0.5 * kg / (1.0 - kr)) * gi - q(0.5 * kb / (1.0 - kr)) * bi;
        return {s, fin(pr, 512), fin(y, 0), fin(pb, 512)};
    endfunction

    task automatic drive_w(input bit v, input logic [3:0] s, input logic [9:0] r, g, b,
                           input bit pin, input logic [9:0] p1, p2, p3);
        exp_t       e;
        logic [1:0] pu;
        @(posedge VCLK); #1;
        vdata_i_valid = v;
        vdata_i       = {s, r, g, b};
        mode_i        = cur_m;
        pu     = pend_m;
        pend_m = (cur_m == 2'b11) ? 2'b00 : cur_m;
        if (v) begin
            if (!s[3] && prev_m) app_m = pu;
            prev_m = s[3];
            e.word = pin ? {s, p1, p2, p3} : model(app_m, s, r, g, b);
            e.mode = app_m;
            e.due  = cyc + 4;
            sb.push_back(e);
        end
    endtask

    task automatic drive(input bit v, input logic [3:0] s, input logic [9:0] r, g, b);
        drive_w(v, s, r, g, b, 1'b0, 10'd0, 10'd0, 10'd0);
    endtask

    task automatic drive_pin(input logic [3:0] s, input logic [9:0] r, g, b, p1, p2, p3);
        drive_w(1'b1, s, r, g, b, 1'b1, p1, p2, p3);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'b1000, 10'd0, 10'd0, 10'd0);
    endtask

    task automatic rnd(input bit v, input bit nvs);
        drive(v, {nvs, 3'($urandom)}, 10'($urandom), 10'($urandom), 10'($urandom));
    endtask

    task automatic reset_dut();
        @(posedge VCLK); #1;
        RST = 1'b1;
        vdata_i_valid = 1'b0;
        @(posedge VCLK); #1;
        RST = 1'b0;
        sb.delete();
        pend_m = 2'b00;  app_m = 2'b00;  prev_m = 1'b1;
        last_out = '0;   last_mode = 2'b00;
        chk("rst_data",  vdata_o, 34'd0);
        chk("rst_valid", vdata_o_valid, 1'b0);
        chk("rst_mode",  mode_o, 2'b00);
    endtask

    // Output monitor: every valid word must match the scoreboard head at
    // exactly its due cycle; gaps must hold data and reported mode.
    always @(negedge VCLK) begin
        exp_t e;
        if (vdata_o_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", 64'(vdata_o_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("latency", 64'(cyc), 64'(e.due));
                chk("word", vdata_o, e.word);
                chk("mode_o", mode_o, e.mode);
            end
            last_out  = vdata_o;
            last_mode = mode_o;
        end else begin
            chk("hold_data", vdata_o, last_out);
            chk("hold_mode", mode_o, last_mode);
            if (sb.size() != 0 && sb[0].due <= cyc) begin
                chk("missing_valid", 64'(vdata_o_valid), 64'd1);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_dut();

        // Rec. 601 applied on the first nVSYNC fall
        cur_m = 2'b01;
        idle(2);
        drive_pin(4'b0101, 10'd1023, 10'd1023, 10'd1023, 10'd512, 10'd1023, 10'd512);
        drive_pin(4'b0110, 10'd1023, 10'd0, 10'd0, 10'd1023, 10'd306, 10'd339);
        idle(1);
        drive_pin(4'b0111, 10'd0, 10'd0, 10'd0, 10'd512, 10'd0, 10'd512);
        drive(1'b1, 4'b1000, 10'd100, 10'd200, 10'd300);

        // Mid-frame request for 709 stays pending; invalid-only fall ignored
        cur_m = 2'b10;
        drive(1'b1, 4'b1001, 10'd400, 10'd500, 10'd600);
        drive(1'b0, 4'b0000, 10'd1, 10'd2, 10'd3);
        drive(1'b1, 4'b1010, 10'd700, 10'd800, 10'd900);
        idle(2);
        drive_pin(4'b0011, 10'd1023, 10'd0, 10'd0, 10'd1023, 10'd217, 10'd395);
        drive_pin(4'b0100, 10'd0, 10'd0, 10'd0, 10'd512, 10'd0, 10'd512);

        // Valid gap pattern 1,0,0,1,1
        rnd(1'b1, 1'b0);
        rnd(1'b0, 1'b0);
        rnd(1'b0, 1'b1);
        rnd(1'b1, 1'b1);
        rnd(1'b1, 1'b1);

        // Random traffic with occasional mode requests and vsync falls
        for (int i = 0; i < 160; i++) begin
            if ($urandom_range(0, 15) == 0) cur_m = 2'($urandom);
            rnd($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0);
        end

        // Mode 11 behaves as passthrough
        cur_m = 2'b11;
        idle(1);
        rnd(1'b1, 1'b1);
        rnd(1'b1, 1'b0);
        rnd(1'b1, 1'b0);

        // Reset mid-stream with 709 applied and three words in flight
        cur_m = 2'b10;
        idle(1);
        rnd(1'b1, 1'b1);
        rnd(1'b1, 1'b0);
        rnd(1'b1, 1'b0);
        rnd(1'b1, 1'b0);
        reset_dut();
        rnd(1'b1, 1'b1);
        rnd(1'b1, 1'b1);
        rnd(1'b1, 1'b1);
        rnd(1'b1, 1'b0);
        rnd(1'b1, 1'b0);

        idle(8);
        chk("drain", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/vconv_gen.md
# vconv_gen

Parametrised successor of the fixed 10-bit RGB-to-YPbPr converter in the PPU output path. It sits between the video post-processing chain and the DAC output registers. It converts `COLOR_W`-bit RGB with a 4-bit sync nibble into RGB passthrough, Rec. 601 YPbPr or Rec. 709 YPbPr. Mode changes take effect only at a vertical-sync boundary, and results are rounded and clamped.

## Interface
Parameters:
- `COLOR_W`, default 10: bits per colour channel (6..12).
- `COEFF_W`, default 20: fractional bits of the fixed-point coefficients (12..24).

Ports:
- `VCLK` in 1: video clock, the single clock domain.
- `RST` in 1: reset, synchronous, active-high.
- `mode_i` in 2: requested mode.
  - 00: RGB passthrough.
  - 01: YPbPr Rec. 601.
  - 10: YPbPr Rec. 709.
  - 11: treated as 00.
- `vdata_i_valid` in 1: input word valid.
- `vdata_i` in 4+3·COLOR_W: input word `{S[3:0], R, G, B}`. `S[3]` is nVSYNC (active-low).
- `vdata_o_valid` out 1: output word valid.
- `vdata_o` out 4+3·COLOR_W: output word `{S, V1, V2, V3}`.
  - RGB mode: V1/V2/V3 = R/G/B.
  - YPbPr modes: V1/V2/V3 = Pr/Y/Pb.
- `mode_o` out 2: mode currently applied at the output stage.

## Operation
- **Pipeline:** free-running, 4 stages.
  - s1 registers input and valid.
  - s2 computes the nine products.
  - s3 sums Y, Pb and Pr.
  - s4 applies offset, rounding, clamp and output select.
- **Valid propagation:** valid shifts through a 4-bit shift register. Sync and RGB are delayed alongside the data so the RGB passthrough stays aligned.
- **Coefficients:** each factor k is computed at elaboration as round(|k|·2^COEFF_W), with its sign handled in the adder.
  - Rec. 601: Kr=0.299, Kb=0.114.
  - Rec. 709: Kr=0.2126, Kb=0.0722.
  - Kg = 1−Kr−Kb.
  - Y = Kr·R + Kg·G + Kb·B.
  - Pb = 0.5·(B−Y)/(1−Kb) + 2^(COLOR_W−1).
  - Pr = 0.5·(R−Y)/(1−Kr) + 2^(COLOR_W−1).
- **Coefficient sets:** both sets are instantiated and selected by the applied mode. A mux on the constant operands is acceptable.
- **Arithmetic widths:**
  - Products are COLOR_W+COEFF_W bits.
  - Sums carry 2 guard bits plus a sign bit.
  - Result = (sum + 2^(COEFF_W−1)) >> COEFF_W, i.e. round-half-up.
  - Results are then clamped to [0, 2^COLOR_W−1]; negative results become 0.
- **Mode latch:**
  - The requested mode is captured into a pending register on every cycle.
  - The applied mode updates from pending only on a valid input whose nVSYNC is 0 while the previous valid input's nVSYNC was 1 (a falling edge; invalid cycles are ignored for edge detection).
  - The new mode applies from that pixel onward. It travels down the pipeline with the pixel, so no output word ever mixes modes.
  - A mode change mid-frame is held pending. If `mode_i` changes again before the edge, only the last value is applied.
- **Output hold:** when the s4 valid is 0, `vdata_o` holds its previous value and `vdata_o_valid` is 0.
- **Reset (`RST`=1 on a clock edge):**
  - Clears all pipeline, valid and mode registers.
  - Applied and pending mode = 00.
  - The edge-detect history is set to nVSYNC=1.
  - Outputs go to zero: `vdata_o`=0, `vdata_o_valid`=0, `mode_o`=00.
  - Reset dominates all other events in the same cycle.

## Timing
- **Latency:** input valid in cycle t gives output valid in cycle t+4, for every mode including passthrough.
- **Throughput:** one word per cycle. Back-to-back valids are sustained with no bubbles, and gaps propagate unchanged.
- **Mode report:** `mode_o` changes in the same cycle as the first output word produced under the new mode.
- **Reset mid-stream:** words in flight are discarded. The first valid input after reset deasserts appears 4 cycles later, in passthrough mode.

## Test plan
- **White, Rec. 601** (COLOR_W=10, COEFF_W=20, mode applied 01): R=G=B=1023 → 4 cycles later V2=1023, V1=V3=512, S unchanged.
- **Saturated red:**
  - Rec. 601, R=1023, G=B=0 → Y=306, Pb=339, Pr=1023 (clamped from 1023.5).
  - Rec. 709, same input → Y=217.
- **Black:** R=G=B=0 in either YPbPr mode → Y=0, Pb=Pr=512.
- **Deferred mode change:**
  - Stimulus: `mode_i` 00→01 mid-frame, then nVSYNC falls on pixel N, with invalid cycles interleaved.
  - Words before pixel N stay RGB; pixel N onward is YPbPr.
  - `mode_o` switches on N's output cycle.
  - A falling edge seen only on invalid cycles does not switch the mode.
- **Valid gaps:** pattern 1,0,0,1,1 → identical pattern on `vdata_o_valid` 4 cycles later, and data holds during the gaps.
- **Reset mid-stream:**
  - Stimulus: `RST` high for 1 cycle with 3 words in flight and mode 10 applied.
  - Next cycle: outputs are 0, `vdata_o_valid`=0, `mode_o`=00.
  - No stale word is ever emitted.
  - Subsequent input passes through as RGB until the next nVSYNC falling edge.
